decoder: RTL and testbench
==========================

# decoder

Receive-side 64b/66b PCS decoder. It sits between the RX gearbox/block-sync stage and the MAC. It collects two 32-bit words plus a 2-bit sync header into one 64-bit block, decodes the block into XGMII-style RS characters with per-byte control flags, and enforces the IEEE 802.3 clause-49 receive sequencing. It emits one decoded 32-bit word per accepted input word.

## Interface
- DATA_WIDTH, 32: input/output word width (fixed; localparam)
- DATA_NBYTES, 4: DATA_WIDTH/8 (localparam)

Ports:
- i_rxc  in  1  receive clock; the only clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_rxd  in  32  scrambler-removed payload word; the first transmitted byte is in [7:0]
- i_rx_header  in  2  sync header; sampled only on the first word of a block
- i_rx_valid  in  1  input word is valid this cycle; low means gearbox pause
- i_frame_word  in  1  0 = first (low) half of a block, 1 = second (high) half
- i_block_lock  in  1  block-sync lock from the lock FSM
- o_rxd  out  32  decoded RS characters
- o_rxctl  out  4  per-byte control flag, 1 = control character
- o_rx_valid  out  1  o_rxd/o_rxctl are updated this cycle
- o_err_count  out  16  present only with DECODER_ERR_COUNT_EN

## Operation
- A word is accepted when i_rx_valid=1. A word0 (i_frame_word=0) latches the data into lo_buf and the header into hdr_buf.
- A word1 (i_frame_word=1) forms the block {i_rxd, lo_buf}. The block is decoded combinationally into a 64-bit character vector and an 8-bit control vector, and the result is registered.
- A word1 without a preceding word0 (after reset or a lost lock) is decoded against lo_buf=0 and hdr_buf=00, which produces an error block.
- Header decode:
  - 01: data; characters = payload, ctl=0x00.
  - 10: control; decoded by block type (below).
  - 00 or 11: error block. All bytes are 0xFE (/E/), ctl=0xFF.
- Block types, using code_defs_pkg constants:
  - 0x1E: eight 7-bit control codes. 0x00 maps to 0x07 (/I/). 0x1E maps to 0xFE. Any other code maps to 0xFE.
  - 0x78 S0: lane0 = 0xFB, lanes1-7 data.
  - 0x33 S4: lanes0-3 = /I/, lane4 = 0xFB.
  - 0x66 O0S4, 0x55 O0O4, 0x4B O0, 0x2D O4: O-code 0x0 maps to 0x9C; O-code 0xF maps to 0x5C.
  - T0-T7 (0x87, 0x99, 0xAA, 0xB4, 0xCC, 0xD2, 0xE1, 0xFF): data lanes are followed by 0xFD, and all remaining lanes are /I/. The encoded pad bits are ignored.
  - Any other type byte is classed E.
- Each block is classed C, S, D, T or E:
  - C = idle or O type.
  - S = S0, S4 or O0S4.
  - D = header 01.
  - T = T0-T7.
  - E = everything else.
- Sequence FSM states: RX_INIT, RX_C, RX_D, RX_E.
  - RX_INIT, RX_C: C → RX_C; S → RX_D; anything else → RX_E.
  - RX_D: D → RX_D; T → RX_C; anything else → RX_E.
  - RX_E: C → RX_C; S → RX_D; anything else stays RX_E.
  - When the next state is RX_E, the emitted block is replaced by the error block.
- If i_block_lock=0: FSM → RX_INIT. The decoded block is forced to local fault: each 32-bit half is {0x01, 0x00, 0x00, 0x9C} with ctl=0x1.
- Output stream:
  - At word1 acceptance: o_rxd ← decoded[31:0] and o_rxctl ← ctl[3:0]; decoded[63:32] is held in hi_buf.
  - At the next accepted word0: o_rxd ← hi_buf and o_rxctl ← hi_ctl.
  - o_rx_valid ← i_rx_valid registered.

## Timing
- Reset values:
  - o_rxd = 0x07070707, o_rxctl = 0xF, o_rx_valid = 0.
  - hi_buf = idle, lo_buf = 0, hdr_buf = 00.
  - FSM = RX_INIT; o_err_count = 0.
- Latency:
  - Low half appears 1 cycle after word1 is accepted.
  - High half appears 1 cycle after the following word0 is accepted.
  - Throughput is one output word per input word.
- i_rx_valid=0: all state holds, o_rx_valid=0, o_rxd holds its last value.
- Lock dropping on a word1 cycle: that block is replaced by local fault.
- Reset asserted mid-block: all state returns to reset values immediately; the partial block is discarded.

## Configuration
- DECODER_ERR_COUNT_EN defined: adds o_err_count, a 16-bit counter.
  - Increments once per block whose FSM next state is RX_E, and saturates at 0xFFFF.
  - Does not count while lock is low.
  - Clears on reset.
- DECODER_ERR_COUNT_EN undefined: the port and the counter are absent; decode behaviour is identical.

## Structure
- code_defs_pkg receives:
  - RS_* and BT_* constants, plus the new LF_SEQ constant.
  - The blk_class_t enum {C, S, D, T, E} and the rx_state_t enum.
  - The cc_to_rs_code() and cc_to_rs_ocode() mapping functions.
- One sub-module, rx_seq_fsm: takes blk_class_t and lock, and outputs the force-error flag and the error pulse.

## Test plan
- Idle stream: header 10, type 0x1E, all control codes 0x00 → o_rxd=0x07070707, o_rxctl=0xF for both halves.
- Frame: S0 block, two D blocks, then T3 (payload 0x00332211) → outputs 0x555555FB/ctl 0x1, then the data words, then 0xFD332211/ctl 0x8, then 0x07070707/ctl 0xF.
- Header 11 mid-frame → that block is 0xFEFEFEFE/ctl 0xF on both halves; the FSM recovers on the next C block.
- D block received in RX_C → error block emitted; with DECODER_ERR_COUNT_EN, o_err_count increments by 1.
- i_block_lock=0 → output 0x0100009C/ctl 0x1 repeated; with pauses (i_rx_valid toggling), o_rx_valid tracks the pauses and no words are lost or duplicated.
- Assert i_reset_n=0 between word0 and word1 → outputs return to reset values at once, and the next complete block decodes correctly.

Source files
------------

// File: rtl/code_defs_pkg.sv
// Shared 64b/66b receive constants, block classes and control-code mapping helpers.
package code_defs_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned DATA_NBYTES = DATA_WIDTH / 8;

    // Sync headers
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // RS (XGMII) characters
    localparam logic [7:0] RS_IDLE   = 8'h07;
    localparam logic [7:0] RS_START  = 8'hFB;
    localparam logic [7:0] RS_TERM   = 8'hFD;
    localparam logic [7:0] RS_ERROR  = 8'hFE;
    localparam logic [7:0] RS_SEQ_OS = 8'h9C;
    localparam logic [7:0] RS_SIG_OS = 8'h5C;

    // 7-bit control codes and 4-bit O-codes
    localparam logic [6:0] CC_IDLE  = 7'h00;
    localparam logic [6:0] CC_ERROR = 7'h1E;
    localparam logic [3:0] OC_SEQ   = 4'h0;
    localparam logic [3:0] OC_SIG   = 4'hF;

    // Block type field values
    localparam logic [7:0] BT_IDLE = 8'h1E;
    localparam logic [7:0] BT_S0   = 8'h78;
    localparam logic [7:0] BT_S4   = 8'h33;
    localparam logic [7:0] BT_O0S4 = 8'h66;
    localparam logic [7:0] BT_O0O4 = 8'h55;
    localparam logic [7:0] BT_O0   = 8'h4B;
    localparam logic [7:0] BT_O4   = 8'h2D;
    localparam logic [7:0] BT_T0   = 8'h87;
    localparam logic [7:0] BT_T1   = 8'h99;
    localparam logic [7:0] BT_T2   = 8'hAA;
    localparam logic [7:0] BT_T3   = 8'hB4;
    localparam logic [7:0] BT_T4   = 8'hCC;
    localparam logic [7:0] BT_T5   = 8'hD2;
    localparam logic [7:0] BT_T6   = 8'hE1;
    localparam logic [7:0] BT_T7   = 8'hFF;

    // Half-block words
    localparam logic [DATA_WIDTH-1:0]  IDLE_WORD = {DATA_NBYTES{RS_IDLE}};
    localparam logic [DATA_NBYTES-1:0] IDLE_CTL  = '1;
    localparam logic [DATA_WIDTH-1:0]  LF_SEQ    = 32'h0100_009C;
    localparam logic [DATA_NBYTES-1:0] LF_CTL    = 4'h1;

    typedef enum logic [2:0] {BlkC, BlkS, BlkD, BlkT, BlkE} blk_class_t;
    typedef enum logic [1:0] {RxInit, RxC, RxD, RxE} rx_state_t;

    function automatic logic [7:0] cc_to_rs_code(input logic [6:0] cc);
        logic [7:0] rs;
        case (cc)
            CC_IDLE:  rs = RS_IDLE;
            CC_ERROR: rs = RS_ERROR;
            default:  rs = RS_ERROR;
        endcase
        return rs;
    endfunction

    function automatic logic [7:0] cc_to_rs_ocode(input logic [3:0] oc);
        logic [7:0] rs;
        case (oc)
            OC_SEQ:  rs = RS_SEQ_OS;
            OC_SIG:  rs = RS_SIG_OS;
            default: rs = RS_ERROR;
        endcase
        return rs;
    endfunction

    // Number of data lanes ahead of /T/; 8 means the type is not a terminate block.
    function automatic logic [3:0] bt_term_lanes(input logic [7:0] bt);
        logic [3:0] n;
        case (bt)
            BT_T0:   n = 4'd0;
            BT_T1:   n = 4'd1;
            BT_T2:   n = 4'd2;
            BT_T3:   n = 4'd3;
            BT_T4:   n = 4'd4;
            BT_T5:   n = 4'd5;
            BT_T6:   n = 4'd6;
            BT_T7:   n = 4'd7;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rx_seq_fsm.sv
// Receive block sequencing FSM: flags blocks that must be replaced by /E/.
module rx_seq_fsm
    import code_defs_pkg::*;
(
    input  logic       i_rxc,
    input  logic       i_reset_n,
    input  logic       i_advance,
    input  blk_class_t i_blk_class,
    input  logic       i_block_lock,
    output logic       o_force_err,
    output logic       o_err_pulse
);

    rx_state_t state_q, state_d, state_nxt;

    // Next-state decode per block class; lock loss returns to init.
    always_comb begin
        state_nxt = RxE;
        case (state_q)
            RxInit, RxC, RxE: begin
                if (i_blk_class == BlkC)      state_nxt = RxC;
                else if (i_blk_class == BlkS) state_nxt = RxD;
                else                          state_nxt = RxE;
            end
            RxD: begin
                if (i_blk_class == BlkD)      state_nxt = RxD;
                else if (i_blk_class == BlkT) state_nxt = RxC;
                else                          state_nxt = RxE;
            end
            default: state_nxt = RxE;
        endcase
        if (!i_block_lock) begin
            state_nxt = RxInit;
        end
        state_d     = i_advance ? state_nxt : state_q;
        o_force_err = (state_nxt == RxE);
        o_err_pulse = i_advance && o_force_err;
    end

    // State register
    always_ff @(posedge i_rxc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= RxInit;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/decoder.sv
// 64b/66b receive PCS decoder: assembles two words into a block, decodes to RS
// characters and enforces receive sequencing. Optional error counter is built
// when DECODER_ERR_COUNT_EN is defined.
module decoder
    import code_defs_pkg::*;
(
    input  logic                   i_rxc,
    input  logic                   i_reset_n,
    input  logic [DATA_WIDTH-1:0]  i_rxd,
    input  logic [1:0]             i_rx_header,
    input  logic                   i_rx_valid,
    input  logic                   i_frame_word,
    input  logic                   i_block_lock,
    output logic [DATA_WIDTH-1:0]  o_rxd,
    output logic [DATA_NBYTES-1:0] o_rxctl,
    output logic                   o_rx_valid
`ifdef DECODER_ERR_COUNT_EN
    ,
    output logic [15:0]            o_err_count
`endif
);

    logic [DATA_WIDTH-1:0]  lo_buf_q, lo_buf_d;
    logic [1:0]             hdr_buf_q, hdr_buf_d;
    logic [DATA_WIDTH-1:0]  hi_buf_q, hi_buf_d;
    logic [DATA_NBYTES-1:0] hi_ctl_q, hi_ctl_d;
    logic [DATA_WIDTH-1:0]  rxd_q, rxd_d;
    logic [DATA_NBYTES-1:0] rxctl_q, rxctl_d;
    logic                   valid_q, valid_d;

    logic [63:0] blk, t_pay, dec_chr, out_chr;
    logic [7:0]  dec_ctl, out_ctl;
    logic [3:0]  term_n;
    blk_class_t  blk_class;
    logic        force_err, err_pulse, word1_acc;

    assign word1_acc = i_rx_valid && i_frame_word;

    // Combinational block decode and classification.
    always_comb begin
        blk       = {i_rxd, lo_buf_q};
        t_pay     = {8'h00, blk[63:8]};
        term_n    = bt_term_lanes(blk[7:0]);
        dec_chr   = {8{RS_ERROR}};
        dec_ctl   = 8'hFF;
        blk_class = BlkE;
        if (hdr_buf_q == SH_DATA) begin
            dec_chr   = blk;
            dec_ctl   = 8'h00;
            blk_class = BlkD;
        end else if (hdr_buf_q == SH_CTRL) begin
            if (term_n < 4'd8) begin
                blk_class = BlkT;
                for (int i = 0; i < 8; i++) begin
                    if (i < int'(term_n)) begin
                        dec_chr[8*i +: 8] = t_pay[8*i +: 8];
                        dec_ctl[i]        = 1'b0;
                    end else if (i == int'(term_n)) begin
                        dec_chr[8*i +: 8] = RS_TERM;
                    end else begin
                        dec_chr[8*i +: 8] = RS_IDLE;
                    end
                end
            end else begin
                case (blk[7:0])
                    BT_IDLE: begin
                        blk_class = BlkC;
                        dec_chr = {cc_to_rs_code(blk[63:57]), cc_to_rs_code(blk[56:50]),
                                   cc_to_rs_code(blk[49:43]), cc_to_rs_code(blk[42:36]),
                                   cc_to_rs_code(blk[35:29]), cc_to_rs_code(blk[28:22]),
                                   cc_to_rs_code(blk[21:15]), cc_to_rs_code(blk[14:8])};
                    end
                    BT_S0: begin
                        blk_class = BlkS;
                        dec_chr   = {blk[63:8], RS_START};
                        dec_ctl   = 8'h01;
                    end
                    BT_S4: begin
                        blk_class = BlkS;
                        dec_chr   = {blk[63:40], RS_START, {4{RS_IDLE}}};
                        dec_ctl   = 8'h1F;
                    end
                    BT_O0S4: begin
                        blk_class = BlkS;
                        dec_chr   = {blk[63:40], RS_START, blk[31:8], cc_to_rs_ocode(blk[35:32])};
                        dec_ctl   = 8'h11;
                    end
                    BT_O0O4: begin
                        blk_class = BlkC;
                        dec_chr   = {blk[63:40], cc_to_rs_ocode(blk[39:36]), blk[31:8],
                                     cc_to_rs_ocode(blk[35:32])};
                        dec_ctl   = 8'h11;
                    end
                    BT_O0: begin
                        blk_class = BlkC;
                        dec_chr   = {cc_to_rs_code(blk[63:57]), cc_to_rs_code(blk[56:50]),
                                     cc_to_rs_code(blk[49:43]), cc_to_rs_code(blk[42:36]),
                                     blk[31:8], cc_to_rs_ocode(blk[35:32])};
                        dec_ctl   = 8'hF1;
                    end
                    BT_O4: begin
                        blk_class = BlkC;
                        dec_chr   = {blk[63:40], cc_to_rs_ocode(blk[39:36]),
                                     cc_to_rs_code(blk[35:29]), cc_to_rs_code(blk[28:22]),
                                     cc_to_rs_code(blk[21:15]), cc_to_rs_code(blk[14:8])};
                        dec_ctl   = 8'h1F;
                    end
                    default: ;
                endcase
            end
        end
    end

    rx_seq_fsm u_rx_seq_fsm (
        .i_rxc        (i_rxc),
        .i_reset_n    (i_reset_n),
        .i_advance    (word1_acc),
        .i_blk_class  (blk_class),
        .i_block_lock (i_block_lock),
        .o_force_err  (force_err),
        .o_err_pulse  (err_pulse)
    );

    // Override decoded block with local fault or /E/ as required.
    always_comb begin
        out_chr = dec_chr;
        out_ctl = dec_ctl;
        if (!i_block_lock) begin
            out_chr = {2{LF_SEQ}};
            out_ctl = {2{LF_CTL}};
        end else if (force_err) begin
            out_chr = {8{RS_ERROR}};
            out_ctl = 8'hFF;
        end
    end

    // Buffer and output stream next-state; buffers are consumed by word1.
    always_comb begin
        lo_buf_d  = lo_buf_q;
        hdr_buf_d = hdr_buf_q;
        hi_buf_d  = hi_buf_q;
        hi_ctl_d  = hi_ctl_q;
        rxd_d     = rxd_q;
        rxctl_d   = rxctl_q;
        valid_d   = i_rx_valid;
        if (i_rx_valid) begin
            if (!i_frame_word) begin
                lo_buf_d  = i_rxd;
                hdr_buf_d = i_rx_header;
                rxd_d     = hi_buf_q;
                rxctl_d   = hi_ctl_q;
            end else begin
                rxd_d     = out_chr[31:0];
                rxctl_d   = out_ctl[3:0];
                hi_buf_d  = out_chr[63:32];
                hi_ctl_d  = out_ctl[7:4];
                lo_buf_d  = '0;
                hdr_buf_d = 2'b00;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge i_rxc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lo_buf_q  <= '0;
            hdr_buf_q <= 2'b00;
            hi_buf_q  <= IDLE_WORD;
            hi_ctl_q  <= IDLE_CTL;
            rxd_q     <= IDLE_WORD;
            rxctl_q   <= IDLE_CTL;
            valid_q   <= 1'b0;
        end else begin
            lo_buf_q  <= lo_buf_d;
            hdr_buf_q <= hdr_buf_d;
            hi_buf_q  <= hi_buf_d;
            hi_ctl_q  <= hi_ctl_d;
            rxd_q     <= rxd_d;
            rxctl_q   <= rxctl_d;
            valid_q   <= valid_d;
        end
    end

    assign o_rxd      = rxd_q;
    assign o_rxctl    = rxctl_q;
    assign o_rx_valid = valid_q;

`ifdef DECODER_ERR_COUNT_EN
    logic [15:0] err_count_q, err_count_d;

    // Saturating count of blocks replaced by /E/.
    always_comb begin
        err_count_d = err_count_q;
        if (err_pulse && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // Error counter register
    always_ff @(posedge i_rxc or negedge i_reset_n) begin
        if (!i_reset_n) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign o_err_count = err_count_q;
`else
    logic unused_err_pulse;
    assign unused_err_pulse = err_pulse;
`endif

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: directed vector table, reset/lock sequences
// and a randomized block stream checked against a character-level model.
module tb_decoder;

    localparam int CL_C = 0, CL_S = 1, CL_D = 2, CL_T = 3, CL_E = 4;
    localparam int K_IDLE = 0, K_S0 = 1, K_S4 = 2, K_D = 3, K_T = 4, K_O0 = 5;
    localparam int K_BADH = 6, K_BADT = 7;

    typedef struct {
        logic [1:0]  hdr;
        logic [63:0] blk;
        logic        lock;
        logic [31:0] lo;
        logic [3:0]  lo_c;
        logic [31:0] hi;
        logic [3:0]  hi_c;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_rxd;
    logic [1:0]  in_hdr;
    logic        in_valid, in_fw, in_lock;
    logic [31:0] o_rxd;
    logic [3:0]  o_rxctl;
    logic        o_rx_valid;
`ifdef DECODER_ERR_COUNT_EN
    logic [15:0] o_err_count;
`endif

    always #5 clk = ~clk;

    decoder dut (
        .i_rxc        (clk),
        .i_reset_n    (rst_n),
        .i_rxd        (in_rxd),
        .i_rx_header  (in_hdr),
        .i_rx_valid   (in_valid),
        .i_frame_word (in_fw),
        .i_block_lock (in_lock),
        .o_rxd        (o_rxd),
        .o_rxctl      (o_rxctl),
        .o_rx_valid   (o_rx_valid)
`ifdef DECODER_ERR_COUNT_EN
        ,
        .o_err_count  (o_err_count)
`endif
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_err  = 0;
    bit          in_pkt   = 1'b0;
    logic [31:0] hi_m     = 32'h07070707;
    logic [3:0]  hi_c_m   = 4'hF;
    logic [31:0] last_rxd = 32'h07070707;
    logic [3:0]  last_ctl = 4'hF;
    logic [7:0]  ttype [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    vec_t        tbl [20];

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic f, input logic [31:0] d,
                         input logic [1:0] h, input logic lk);
        @(negedge clk);
        in_valid = v;
        in_fw    = f;
        in_rxd   = d;
        in_hdr   = h;
        in_lock  = lk;
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n, input logic lk);
        for (int g = 0; g < n; g++) begin
            cycle(1'b0, 1'($urandom), $urandom, 2'($urandom), lk);
            chk("pause valid", 36'(o_rx_valid), 36'd0);
            chk("pause hold", {o_rxd, o_rxctl}, {last_rxd, last_ctl});
        end
    endtask

    task automatic reset_model();
        hi_m     = 32'h07070707;
        hi_c_m   = 4'hF;
        last_rxd = 32'h07070707;
        last_ctl = 4'hF;
        in_pkt   = 1'b0;
        exp_err  = 0;
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, " rxd/ctl"}, {o_rxd, o_rxctl}, {32'h07070707, 4'hF});
        chk({name, " valid"}, 36'(o_rx_valid), 36'd0);
`ifdef DECODER_ERR_COUNT_EN
        chk({name, " err_count"}, 36'(o_err_count), 36'd0);
`endif
    endtask

    // Send word1 alone and check its low half.
    task automatic send_word1(input string name, input logic [31:0] d, input logic lk,
                              input logic [63:0] echr, input logic [7:0] ectl);
        cycle(1'b1, 1'b1, d, 2'($urandom), lk);
        chk({name, " valid1"}, 36'(o_rx_valid), 36'd1);
        chk({name, " lo"}, {o_rxd, o_rxctl}, {echr[31:0], ectl[3:0]});
        last_rxd = echr[31:0];
        last_ctl = ectl[3:0];
        hi_m     = echr[63:32];
        hi_c_m   = ectl[7:4];
`ifdef DECODER_ERR_COUNT_EN
        chk({name, " err_count"}, 36'(o_err_count), 36'(exp_err));
`endif
    endtask

    task automatic send_block(input string name, input logic [1:0] h, input logic [63:0] b,
                              input logic lk, input logic [63:0] echr, input logic [7:0] ectl,
                              input int max_gap);
        gap($urandom_range(0, max_gap), lk);
        cycle(1'b1, 1'b0, b[31:0], h, lk);
        chk({name, " valid0"}, 36'(o_rx_valid), 36'd1);
        chk({name, " hi(prev)"}, {o_rxd, o_rxctl}, {hi_m, hi_c_m});
        last_rxd = hi_m;
        last_ctl = hi_c_m;
        gap($urandom_range(0, max_gap), lk);
        send_word1(name, b[63:32], lk, echr, ectl);
    endtask

    // Sequencing rules: outside a packet only C/S are legal; inside only D/T.
    task automatic apply_seq(input logic lk, input int cls,
                             inout logic [63:0] chr, inout logic [7:0] ctl);
        bit ok;
        if (!lk) begin
            chr    = {2{32'h0100009C}};
            ctl    = 8'h11;
            in_pkt = 1'b0;
        end else begin
            ok = in_pkt ? (cls == CL_D || cls == CL_T) : (cls == CL_C || cls == CL_S);
            if (!ok) begin
                chr = {8{8'hFE}};
                ctl = 8'hFF;
                exp_err++;
                in_pkt = 1'b0;
            end else begin
                in_pkt = (cls == CL_S) || (cls == CL_D);
            end
        end
    endtask

    // Encoder: choose lane characters, then pack them into a 66b block.
    task automatic gen_block(input int kind, output logic [1:0] h, output logic [63:0] b,
                             output logic [63:0] chr, output logic [7:0] ctl, output int cls);
        logic [7:0]  l [8];
        logic [63:0] rnd;
        logic [7:0]  t;
        logic [3:0]  oc;
        int          n;
        rnd = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) l[i] = 8'h07;
        h   = 2'b10;
        b   = rnd;
        ctl = 8'hFF;
        cls = CL_E;
        case (kind)
            K_IDLE: begin
                b   = 64'h1E;
                cls = CL_C;
            end
            K_S0: begin
                l[0] = 8'hFB;
                for (int i = 1; i < 8; i++) l[i] = rnd[8*i +: 8];
                b   = {rnd[63:8], 8'h78};
                ctl = 8'h01;
                cls = CL_S;
            end
            K_S4: begin
                l[4] = 8'hFB;
                for (int i = 5; i < 8; i++) l[i] = rnd[8*i +: 8];
                b   = {rnd[63:40], 32'h0, 8'h33};
                ctl = 8'h1F;
                cls = CL_S;
            end
            K_D: begin
                h = 2'b01;
                for (int i = 0; i < 8; i++) l[i] = rnd[8*i +: 8];
                ctl = 8'h00;
                cls = CL_D;
            end
            K_T: begin
                n = $urandom_range(0, 7);
                for (int i = 0; i < n; i++) l[i] = rnd[8*(i+1) +: 8];
                l[n] = 8'hFD;
                b    = {rnd[63:8], ttype[n]};
                ctl  = 8'hFF << n;
                cls  = CL_T;
            end
            K_O0: begin
                oc   = $urandom_range(0, 1) ? 4'hF : 4'h0;
                l[0] = (oc == 4'hF) ? 8'h5C : 8'h9C;
                for (int i = 1; i < 4; i++) l[i] = rnd[8*i +: 8];
                b   = {28'h0, oc, rnd[31:8], 8'h4B};
                ctl = 8'hF1;
                cls = CL_C;
            end
            K_BADH: begin
                h = $urandom_range(0, 1) ? 2'b11 : 2'b00;
                for (int i = 0; i < 8; i++) l[i] = 8'hFE;
            end
            default: begin
                do t = 8'($urandom);
                while (t inside {8'h1E, 8'h78, 8'h33, 8'h66, 8'h55, 8'h4B, 8'h2D, 8'h87,
                                 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF});
                b = {rnd[63:8], t};
                for (int i = 0; i < 8; i++) l[i] = 8'hFE;
            end
        endcase
        for (int i = 0; i < 8; i++) chr[8*i +: 8] = l[i];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  h;
        logic [63:0] b, chr;
        logic [7:0]  ctl;
        logic        lk;
        int          cls, kind, r;

        tbl[0]  = '{2'b10, 64'h0000_0000_0000_001E, 1'b1, 32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0};
        tbl[1]  = '{2'b10, 64'h5555_5555_5555_5578, 1'b1, 32'h555555FB, 4'h1, 32'h55555555, 4'h0, 1'b0};
        tbl[2]  = '{2'b01, 64'h0807_0605_0403_0201, 1'b1, 32'h04030201, 4'h0, 32'h08070605, 4'h0, 1'b0};
        tbl[3]  = '{2'b01, 64'h1817_1615_1413_1211, 1'b1, 32'h14131211, 4'h0, 32'h18171615, 4'h0, 1'b0};
        tbl[4]  = '{2'b10, 64'h0000_0000_3322_11B4, 1'b1, 32'hFD332211, 4'h8, 32'h07070707, 4'hF, 1'b0};
        tbl[5]  = '{2'b10, 64'h0000_0000_0000_001E, 1'b1, 32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0};
        tbl[6]  = '{2'b10, 64'h5555_5555_5555_5578, 1'b1, 32'h555555FB, 4'h1, 32'h55555555, 4'h0, 1'b0};
        tbl[7]  = '{2'b11, 64'h0123_4567_89AB_CDEF, 1'b1, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1};
        tbl[8]  = '{2'b10, 64'h0000_0000_0000_001E, 1'b1, 32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0};
        tbl[9]  = '{2'b01, 64'h1111_1111_1111_1111, 1'b1, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1};
        tbl[10] = '{2'b10, 64'h0000_0000_0000_001E, 1'b1, 32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0};
        tbl[11] = '{2'b10, 64'hA3A2_A100_0000_0033, 1'b1, 32'h07070707, 4'hF, 32'hA3A2A1FB, 4'h1, 1'b0};
        tbl[12] = '{2'b10, 64'h0000_0000_0000_0087, 1'b1, 32'h070707FD, 4'hF, 32'h07070707, 4'hF, 1'b0};
        tbl[13] = '{2'b10, 64'h0000_0000_3322_114B, 1'b1, 32'h3322119C, 4'h1, 32'h07070707, 4'hF, 1'b0};
        tbl[14] = '{2'b10, 64'h0000_0000_0000_0012, 1'b1, 32'hFEFEFEFE, 4'hF, 32'hFEFEFEFE, 4'hF, 1'b1};
        tbl[15] = '{2'b10, 64'h0000_0000_0000_001E, 1'b1, 32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0};
        tbl[16] = '{2'b10, 64'h0000_0000_0000_1E1E, 1'b1, 32'h070707FE, 4'hF, 32'h07070707, 4'hF, 1'b0};
        tbl[17] = '{2'b10, 64'h0000_0000_0000_001E, 1'b0, 32'h0100009C, 4'h1, 32'h0100009C, 4'h1, 1'b0};
        tbl[18] = '{2'b10, 64'h5555_5555_5555_5578, 1'b1, 32'h555555FB, 4'h1, 32'h55555555, 4'h0, 1'b0};
        tbl[19] = '{2'b10, 64'h0706_0504_0302_01FF, 1'b1, 32'h04030201, 4'h0, 32'hFD070605, 4'h8, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_fw    = 1'b0;
        in_rxd   = '0;
        in_hdr   = 2'b00;
        in_lock  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            exp_err += int'(tbl[i].err);
            send_block($sformatf("vec%0d", i), tbl[i].hdr, tbl[i].blk, tbl[i].lock,
                       {tbl[i].hi, tbl[i].lo}, {tbl[i].hi_c, tbl[i].lo_c}, 1);
        end
        in_pkt = 1'b0;

        // Reset between word0 and word1
        cycle(1'b1, 1'b0, 32'h5555_5578, 2'b10, 1'b1);
        chk("midrst word0", {o_rxd, o_rxctl}, {hi_m, hi_c_m});
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_state("midrst async");
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        send_block("post-reset idle", 2'b10, 64'h1E, 1'b1, {2{32'h07070707}}, 8'hFF, 0);

        // Word1 with no preceding word0 decodes as an error block
        chr = '0;
        ctl = '0;
        apply_seq(1'b1, CL_E, chr, ctl);
        send_word1("orphan word1", 32'h1234_5678, 1'b1, chr, ctl);
        send_block("recover idle", 2'b10, 64'h1E, 1'b1, {2{32'h07070707}}, 8'hFF, 0);

        // Lock low with pauses: local fault on every word, none lost
        for (int k = 0; k < 5; k++) begin
            chr = '0;
            ctl = '0;
            apply_seq(1'b0, CL_C, chr, ctl);
            send_block($sformatf("nolock%0d", k), 2'b10, 64'h1E, 1'b0, chr, ctl, 3);
        end

        // Randomized block stream
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (in_pkt) begin
                kind = (r < 60) ? K_D : (r < 92) ? K_T : (r < 96) ? K_BADH : K_IDLE;
            end else begin
                kind = (r < 35) ? K_IDLE : (r < 55) ? K_S0 : (r < 65) ? K_S4 :
                       (r < 80) ? K_O0 : (r < 88) ? K_BADH : (r < 94) ? K_BADT : K_D;
            end
            lk = ($urandom_range(0, 99) >= 4);
            gen_block(kind, h, b, chr, ctl, cls);
            apply_seq(lk, cls, chr, ctl);
            send_block($sformatf("rand%0d k%0d", k, kind), h, b, lk, chr, ctl, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
